alarm_mgr: RTL
==============

Name: alarm_mgr

Overview:
Parametrised successor to the single-sensor fish-tank alarm. Monitors N_GAS active-low digital gas sensors (each synchronised and debounced) plus a DHT11 temperature value with hysteresis. A 3-state alarm FSM drives a pulsed active-low buzzer with acknowledge/mute, and a duty-programmable fan PWM. It sits between the sensor front-ends (MQ-2 pins, DHT11 reader) and the buzzer/fan pins.

Parameters:
N_GAS, 2, number of active-low gas sensor inputs (1..8)
TEMP_W, 8, temperature width, unsigned °C
TEMP_HI, 40, over-temp set threshold (temp >= TEMP_HI)
TEMP_LO, 37, over-temp clear threshold (temp <= TEMP_LO); must be < TEMP_HI
DEBOUNCE_CYC, 500, consecutive mismatching cycles before a debounced gas bit changes
PWM_PERIOD, 2000, fan PWM period in clk cycles (25 kHz at 50 MHz)
DUTY_GAS, 2000, fan high-cycles per period when any gas cause is active
DUTY_TEMP, 1000, fan high-cycles per period when only temperature is active
BEEP_CYC, 12500000, buzzer on-time and off-time in cycles (0.25 s at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
gas_n  in  N_GAS  raw sensor inputs; low = gas detected; asynchronous
temperature  in  TEMP_W  temperature value
temp_valid  in  1  one-cycle strobe; temperature is sampled only when high
ack  in  1  one-cycle acknowledge pulse (mute / clear latch)
buzzer_n  out  1  buzzer drive, active-low
fan_pwm  out  1  fan PWM
alarm_active  out  1  FSM is in ALARM
alarm_cause  out  N_GAS+1  bit i = debounced gas i active; bit N_GAS = over-temp

Behaviour:
- Reset: rst_n is sampled on clk; rst_n low is synchronous and active-low. Reset sets buzzer_n=1, fan_pwm=0, alarm_active=0, alarm_cause=0, and the FSM to NORMAL. Synchronisers reset to 1. Debounced states reset to 1 (normal). All counters, the mute flag and over_temp reset to 0. Reset asserted mid-alarm returns every output to its reset value on the next edge.
- Gas path: each gas_n bit passes through a 2-flop synchroniser, then a per-channel debouncer. The mismatch counter increments while the synchronised value != the debounced state and clears to 0 on any match. When the counter reaches DEBOUNCE_CYC-1 during a mismatch, the debounced state takes the new value and the counter clears. A glitch shorter than DEBOUNCE_CYC cycles never propagates. Latency from an input edge to alarm_cause is DEBOUNCE_CYC+3 cycles.
- Temperature: over_temp is updated only when temp_valid=1. It is set if temperature >= TEMP_HI and cleared if temperature <= TEMP_LO; otherwise it holds. Comparisons are unsigned. alarm_cause[N_GAS] equals over_temp, one cycle after the strobe.
- cause_any is the OR of alarm_cause.
- FSM states: NORMAL, ALARM, LATCHED.
  - NORMAL -> ALARM when cause_any=1. Entry clears mute and the beep counter.
  - ALARM -> LATCHED when cause_any=0.
  - ALARM: ack sets mute. The fan is unaffected by ack.
  - LATCHED -> NORMAL on ack.
  - LATCHED -> ALARM when cause_any=1 again. This re-entry clears mute.
  - If ack and cause_any=1 arrive in the same cycle in LATCHED, cause wins and the FSM goes to ALARM.
- Outputs are registered and follow the state with 1 cycle latency.
- Buzzer:
  - ALARM and not muted: buzzer_n toggles every BEEP_CYC cycles, starting low (on) on the first ALARM cycle.
  - LATCHED: buzzer_n=1.
  - NORMAL: buzzer_n=1.
- Fan:
  - The PWM counter runs 0..PWM_PERIOD-1 and wraps to 0.
  - fan_pwm = (cnt < duty_q).
  - duty_q is reloaded only when cnt wraps to 0, so there are no partial pulses.
  - Target duty: DUTY_GAS if any gas bit is set (gas has priority over temperature); else DUTY_TEMP if in ALARM; else 0.
  - A duty of PWM_PERIOD or more gives a constant 1. A duty of 0 gives a constant 0.
  - In LATCHED and NORMAL the target is 0.
- Counter widths are $clog2 of each maximum, plus 1 where needed. There is no wrap except where specified.

Optional Feature:
ALARM_LATCH_EN.
- Defined: LATCHED state present as described above.
- Undefined: LATCHED does not exist. ALARM -> NORMAL directly when cause_any=0, and ack only mutes the buzzer.

Decomposition:
- Package alarm_pkg holds:
  - the state enum (NORMAL=2'd0, ALARM=2'd1, LATCHED=2'd2);
  - the constant TEMP_BIT index helper;
  - default timing constants.
- Sub-module alarm_debounce (synchroniser plus debounce for one channel, parameter DEBOUNCE_CYC) is instantiated N_GAS times with a generate loop.

Test Plan:
All scenarios use sim parameters N_GAS=2, DEBOUNCE_CYC=4, PWM_PERIOD=10, DUTY_GAS=10, DUTY_TEMP=5, BEEP_CYC=3, TEMP_HI=40, TEMP_LO=37.
- Reset: hold rst_n=0 for 3 clk -> buzzer_n=1, fan_pwm=0, alarm_cause=0, alarm_active=0. Repeat with reset mid-ALARM -> same.
- Debounce: gas_n[0] low for 3 cycles then high -> no cause. Low for 10 cycles -> alarm_cause=3'b001 exactly 7 cycles after the edge, and alarm_active next cycle.
- Temperature hysteresis: strobe 39, then 40 -> over_temp=1. Strobe 38 -> stays 1. Strobe 37 -> clears. A value of 45 with temp_valid=0 is ignored.
- Fan and buzzer: temperature-only alarm -> fan_pwm high 5 of every 10 cycles. Adding gas[1] -> duty changes to constant high only at the wrap. buzzer_n pattern is 0,0,0,1,1,1,...
- Acknowledge: ack in ALARM -> buzzer_n=1 while fan keeps running. Cause clears -> LATCHED. ack -> NORMAL. ack coincident with a new cause in LATCHED -> ALARM with mute cleared.
- Latch feature: build without ALARM_LATCH_EN -> cause clear returns the FSM directly to NORMAL, and alarm_active drops 1 cycle later.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the multi-sensor alarm manager.
package alarm_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ALARM   = 2'd1,
        LATCHED = 2'd2
    } alarm_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYC = 500;
    localparam int unsigned DEF_PWM_PERIOD   = 2000;
    localparam int unsigned DEF_DUTY_GAS     = 2000;
    localparam int unsigned DEF_DUTY_TEMP    = 1000;
    localparam int unsigned DEF_BEEP_CYC     = 12500000;
    localparam int unsigned DEF_TEMP_HI      = 40;
    localparam int unsigned DEF_TEMP_LO      = 37;

    // Over-temperature sits just above the gas bits in alarm_cause.
    function automatic int unsigned temp_bit(input int unsigned n_gas);
        return n_gas;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/alarm_debounce.sv
// One gas channel: 2-flop synchroniser followed by a mismatch-count debouncer.
module alarm_debounce
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Inputs idle high, so the synchroniser and debounced state reset to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != deb) begin
                if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alarm_mgr.sv
// Gas/temperature alarm manager with pulsed buzzer and fan PWM.
// Build option ALARM_LATCH_EN keeps a LATCHED state after causes clear until ack.
module alarm_mgr
    import alarm_pkg::*;
#(
    parameter int unsigned N_GAS        = 2,
    parameter int unsigned TEMP_W       = 8,
    parameter int unsigned TEMP_HI      = DEF_TEMP_HI,
    parameter int unsigned TEMP_LO      = DEF_TEMP_LO,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned PWM_PERIOD   = DEF_PWM_PERIOD,
    parameter int unsigned DUTY_GAS     = DEF_DUTY_GAS,
    parameter int unsigned DUTY_TEMP    = DEF_DUTY_TEMP,
    parameter int unsigned BEEP_CYC     = DEF_BEEP_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_GAS-1:0]  gas_n,
    input  logic [TEMP_W-1:0] temperature,
    input  logic              temp_valid,
    input  logic              ack,
    output logic              buzzer_n,
    output logic              fan_pwm,
    output logic              alarm_active,
    output logic [N_GAS:0]    alarm_cause
);

    localparam int unsigned TEMP_BIT  = temp_bit(N_GAS);
    localparam int unsigned DUTY_MAX0 = (DUTY_GAS > DUTY_TEMP) ? DUTY_GAS : DUTY_TEMP;
    localparam int unsigned DUTY_MAX  = (DUTY_MAX0 > PWM_PERIOD) ? DUTY_MAX0 : PWM_PERIOD;
    localparam int unsigned PWM_W     = $clog2(DUTY_MAX + 1);
    localparam int unsigned BEEP_W    = cnt_width(BEEP_CYC);

    logic [N_GAS-1:0]  deb;
    logic [N_GAS-1:0]  gas_cause;
    logic              over_temp;
    logic              cause_any_c;
    logic              gas_any_c;
    alarm_state_e      state;
    logic              mute;
    logic              beep_on;
    logic [BEEP_W-1:0] beep_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  duty_q;
    logic [PWM_W-1:0]  duty_tgt_c;

    for (genvar g = 0; g < N_GAS; g++) begin : g_deb
        alarm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (gas_n[g]),
            .deb   (deb[g])
        );
    end

    // Cause register: active-high gas bits plus hysteretic over-temperature.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gas_cause <= '0;
            over_temp <= 1'b0;
        end else begin
            gas_cause <= ~deb;
            if (temp_valid) begin
                if (temperature >= TEMP_W'(TEMP_HI)) begin
                    over_temp <= 1'b1;
                end else if (temperature <= TEMP_W'(TEMP_LO)) begin
                    over_temp <= 1'b0;
                end
            end
        end
    end

    assign alarm_cause[N_GAS-1:0] = gas_cause;
    assign alarm_cause[TEMP_BIT]  = over_temp;
    assign cause_any_c            = |alarm_cause;
    assign gas_any_c              = |gas_cause;

    // Alarm FSM; buzzer_n is decided alongside the transition so it leads with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= NORMAL;
            alarm_active <= 1'b0;
            buzzer_n     <= 1'b1;
            mute         <= 1'b0;
            beep_on      <= 1'b0;
            beep_cnt     <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (cause_any_c) begin
                        state        <= ALARM;
                        alarm_active <= 1'b1;
                        buzzer_n     <= 1'b0;
                        mute         <= 1'b0;
                        beep_on      <= 1'b1;
                        beep_cnt     <= '0;
                    end
                end
                ALARM: begin
                    if (!cause_any_c) begin
`ifdef ALARM_LATCH_EN
                        state <= LATCHED;
`else
                        state <= NORMAL;
`endif
                        alarm_active <= 1'b0;
                        buzzer_n     <= 1'b1;
                    end else begin
                        if (ack) begin
                            mute <= 1'b1;
                        end
                        if (beep_cnt == BEEP_W'(BEEP_CYC - 1)) begin
                            beep_cnt <= '0;
                            beep_on  <= ~beep_on;
                            buzzer_n <= beep_on | mute | ack;
                        end else begin
                            beep_cnt <= beep_cnt + BEEP_W'(1);
                            buzzer_n <= ~beep_on | mute | ack;
                        end
                    end
                end
`ifdef ALARM_LATCH_EN
                LATCHED: begin
                    // A returning cause outranks a coincident ack.
                    if (cause_any_c) begin
                        state        <= ALARM;
                        alarm_active <= 1'b1;
                        buzzer_n     <= 1'b0;
                        mute         <= 1'b0;
                        beep_on      <= 1'b1;
                        beep_cnt     <= '0;
                    end else if (ack) begin
                        state <= NORMAL;
                    end
                end
`endif
                default: begin
                    state        <= NORMAL;
                    alarm_active <= 1'b0;
                    buzzer_n     <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        duty_tgt_c = '0;
        if (state == ALARM) begin
            duty_tgt_c = gas_any_c ? PWM_W'(DUTY_GAS) : PWM_W'(DUTY_TEMP);
        end
    end

    // Fan PWM; duty only reloads at the wrap so every period is whole.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
            fan_pwm <= 1'b0;
        end else if (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) begin
            pwm_cnt <= '0;
            duty_q  <= duty_tgt_c;
            fan_pwm <= (duty_tgt_c != '0);
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            fan_pwm <= (pwm_cnt + PWM_W'(1)) < duty_q;
        end
    end

endmodule
